// File: rtl/wb_wdt_timer.sv
// ============================================================================
// wb_wdt_timer : Wishbone prescaled down-counter with a watchdog warm-boot latch
// Revision     : 1.0
// ============================================================================
`default_nettype none

module wb_wdt_timer #(
   parameter int TIMER_WIDTH    = 24,
   parameter int PRESCALE_WIDTH = 8,
   parameter int DW             = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          wb_addr,
   output logic [DW-1:0]       wb_rdata,
   input  logic [DW-1:0]       wb_wdata,
   input  logic                wb_we,
   input  logic                wb_cyc,
   output logic                wb_ack,
   output logic                irq,
   output logic                boot_now,
   output logic [1:0]          boot_sel
);

   localparam logic [1:0]    c_addr_csr    = 2'd0;
   localparam logic [1:0]    c_addr_reload = 2'd1;
   localparam logic [1:0]    c_addr_count  = 2'd2;
   localparam logic [1:0]    c_addr_kick   = 2'd3;
   localparam logic [DW-1:0] c_kick_key    = DW'(32'h0000_5AA5);

   logic                      ack_q, ack_d;
   logic [DW-1:0]             rdata_q, rdata_d;
   logic                      run_q, run_d;
   logic                      wdt_en_q, wdt_en_d;
   logic                      periodic_q, periodic_d;
   logic                      expired_q, expired_d;
   logic [1:0]                wdt_sel_q, wdt_sel_d;
   logic [PRESCALE_WIDTH-1:0] div_q, div_d;
   logic [PRESCALE_WIDTH-1:0] pc_q, pc_d;
   logic [TIMER_WIDTH-1:0]    reload_q, reload_d;
   logic [TIMER_WIDTH-1:0]    count_q, count_d;
   logic                      boot_now_q, boot_now_d;
   logic [1:0]                boot_sel_q, boot_sel_d;

   logic          access, wr, csr_wr, reload_wr, count_wr, kick_ok;
   logic          tick, expire_evt;
   logic [DW-1:0] csr_val, rd_mux;

   always_comb begin
      // A new access is accepted only when no ack is outstanding.
      access    = wb_cyc && !ack_q;
      wr        = access && wb_we;
      csr_wr    = wr && (wb_addr == c_addr_csr);
      reload_wr = wr && (wb_addr == c_addr_reload);
      count_wr  = wr && (wb_addr == c_addr_count);
      kick_ok   = wr && (wb_addr == c_addr_kick) && (wb_wdata == c_kick_key);

      tick = run_q && (pc_q == div_q);

      csr_val                          = '0;
      csr_val[0]                       = run_q;
      csr_val[1]                       = wdt_en_q;
      csr_val[2]                       = periodic_q;
      csr_val[3]                       = expired_q;
      csr_val[5:4]                     = wdt_sel_q;
      csr_val[8 +: PRESCALE_WIDTH]     = div_q;

      case (wb_addr)
         c_addr_csr:    rd_mux = csr_val;
         c_addr_reload: rd_mux = DW'(reload_q);
         c_addr_count:  rd_mux = DW'(count_q);
         default:       rd_mux = '0;
      endcase

      ack_d   = access;
      rdata_d = (access && !wb_we) ? rd_mux : '0;

      run_d      = run_q;
      wdt_en_d   = wdt_en_q;
      periodic_d = periodic_q;
      wdt_sel_d  = wdt_sel_q;
      div_d      = div_q;
      if (csr_wr) begin
         run_d      = wb_wdata[0];
         wdt_en_d   = wdt_en_q | wb_wdata[1];
         periodic_d = wb_wdata[2];
         wdt_sel_d  = wb_wdata[5:4];
         div_d      = wb_wdata[8 +: PRESCALE_WIDTH];
      end

      if (!run_q || tick) begin
         pc_d = '0;
      end else begin
         pc_d = pc_q + PRESCALE_WIDTH'(1);
      end
      if (csr_wr && (wb_wdata[8 +: PRESCALE_WIDTH] != div_q)) begin
         pc_d = '0;
      end

      reload_d = reload_wr ? wb_wdata[TIMER_WIDTH-1:0] : reload_q;

      // Bus writes and valid kicks pre-empt a coinciding tick entirely.
      expire_evt = 1'b0;
      count_d    = count_q;
      if (count_wr) begin
         count_d = wb_wdata[TIMER_WIDTH-1:0];
      end else if (kick_ok) begin
         count_d = reload_q;
      end else if (tick) begin
         if (count_q > TIMER_WIDTH'(1)) begin
            count_d = count_q - TIMER_WIDTH'(1);
         end else if (count_q == TIMER_WIDTH'(1)) begin
            expire_evt = 1'b1;
            count_d    = periodic_q ? reload_q : '0;
         end
      end

      expired_d = expired_q;
      if (csr_wr && wb_wdata[3]) begin
         expired_d = 1'b0;
      end
      if (expire_evt) begin
         expired_d = 1'b1;
      end

      boot_now_d = boot_now_q;
      boot_sel_d = boot_sel_q;
      if (expire_evt && wdt_en_q && !boot_now_q) begin
         boot_now_d = 1'b1;
         boot_sel_d = wdt_sel_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_q      <= 1'b0;
         rdata_q    <= '0;
         run_q      <= 1'b0;
         wdt_en_q   <= 1'b0;
         periodic_q <= 1'b0;
         expired_q  <= 1'b0;
         wdt_sel_q  <= '0;
         div_q      <= '0;
         pc_q       <= '0;
         reload_q   <= '0;
         count_q    <= '0;
         boot_now_q <= 1'b0;
         boot_sel_q <= '0;
      end else begin
         ack_q      <= ack_d;
         rdata_q    <= rdata_d;
         run_q      <= run_d;
         wdt_en_q   <= wdt_en_d;
         periodic_q <= periodic_d;
         expired_q  <= expired_d;
         wdt_sel_q  <= wdt_sel_d;
         div_q      <= div_d;
         pc_q       <= pc_d;
         reload_q   <= reload_d;
         count_q    <= count_d;
         boot_now_q <= boot_now_d;
         boot_sel_q <= boot_sel_d;
      end
   end

   assign wb_ack   = ack_q;
   assign wb_rdata = rdata_q;
   assign irq      = expired_q;
   assign boot_now = boot_now_q;
   assign boot_sel = boot_sel_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_wdt_timer.sv
// ============================================================================
// tb_wb_wdt_timer : self-checking bench for wb_wdt_timer
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_wb_wdt_timer;

   localparam int TW = 24;
   localparam int PW = 8;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    wb_addr = '0;
   logic [DW-1:0] wb_wdata = '0;
   logic [DW-1:0] wb_rdata;
   logic          wb_we = 1'b0;
   logic          wb_cyc = 1'b0;
   logic          wb_ack;
   logic          irq;
   logic          boot_now;
   logic [1:0]    boot_sel;

   int errors = 0;
   int checks = 0;
   int cyc_cnt = 0;

   wb_wdt_timer #(.TIMER_WIDTH(TW), .PRESCALE_WIDTH(PW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .wb_addr(wb_addr), .wb_rdata(wb_rdata),
      .wb_wdata(wb_wdata), .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack),
      .irq(irq), .boot_now(boot_now), .boot_sel(boot_sel)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   initial begin
      #400000;
      $display("FAIL global_timeout cycles=%0d", cyc_cnt);
      $fatal(1);
   end

   // Holds wb_cyc until an ack arrives; edge_no is the edge that raised it.
   task automatic bus(input logic [1:0] a, input logic we, input logic [31:0] d,
                      output logic [31:0] rd, output int edge_no);
      int n;
      wb_addr = a; wb_we = we; wb_wdata = d; wb_cyc = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!wb_ack && n < 8);
      checks++;
      if (wb_ack !== 1'b1) begin
         errors++;
         $display("FAIL bus_ack_timeout addr=%0d ack=%b expected 1", a, wb_ack);
      end
      rd = wb_rdata;
      edge_no = cyc_cnt;
      wb_cyc = 1'b0; wb_we = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d, output int e);
      logic [31:0] dummy;
      bus(a, 1'b1, d, dummy, e);
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d, output int e);
      bus(a, 1'b0, 32'h0, d, e);
   endtask

   task automatic wait_until(input int target);
      while (cyc_cnt < target) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #3;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      int e;
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({wb_ack, wb_rdata, irq, boot_now, boot_sel} !== '0) begin
         errors++;
         $display("FAIL reset_initial outs=%h expected 0", {wb_ack, wb_rdata, irq, boot_now, boot_sel});
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      wr(2'd1, 32'd100, e);
      wr(2'd2, 32'd100, e);
      wr(2'd0, 32'h0000_0301, e);
      wait_until(e + 7);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({wb_ack, wb_rdata, irq, boot_now, boot_sel} !== '0) begin
         errors++;
         $display("FAIL reset_midcount outs=%h expected 0", {wb_ack, wb_rdata, irq, boot_now, boot_sel});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int a = 0; a < 4; a++) begin
         rd(2'(a), d, e);
         checks++;
         if (d !== 32'h0) begin
            errors++;
            $display("FAIL reset_readback addr=%0d got=%h expected 0", a, d);
         end
      end
   endtask

   task automatic test_oneshot();
      logic [31:0] d;
      int e, n, dv, total, expct, rise, r;
      for (int it = 0; it < 4; it++) begin
         do_reset();
         if (it == 0) begin n = 5; dv = 1; end
         else begin n = $urandom_range(1, 20); dv = $urandom_range(0, 5); end
         total = n * (dv + 1);
         wr(2'd1, 32'(n), e);
         wr(2'd2, 32'(n), e);
         wr(2'd0, 32'((dv << 8) | 1), e);
         expct = e + total;
         if (total >= 3) begin
            wait_until(e + $urandom_range(1, total - 2));
            rd(2'd2, d, r);
            checks++;
            if (d !== 32'(n - (r - 1 - e) / (dv + 1))) begin
               errors++;
               $display("FAIL oneshot_midcount n=%0d div=%0d got=%0d expected=%0d", n, dv, d, n - (r - 1 - e) / (dv + 1));
            end
         end
         rise = -1;
         while (cyc_cnt <= expct + 2) begin
            if (irq === 1'b1 && rise < 0) rise = cyc_cnt;
            @(posedge clk); #1;
         end
         checks++;
         if (rise != expct) begin
            errors++;
            $display("FAIL oneshot_irq_time n=%0d div=%0d got=%0d expected=%0d", n, dv, rise - e, total);
         end
         rd(2'd2, d, r);
         wait_until(r + 2 * (dv + 1) + 3);
         rd(2'd2, d, r);
         checks++;
         if (d !== 32'h0 || boot_now !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_stopped count=%0d boot_now=%b expected 0/0", d, boot_now);
         end
      end
   endtask

   task automatic test_periodic();
      logic [31:0] d;
      int e, w, r;
      do_reset();
      wr(2'd1, 32'd3, e);
      wr(2'd2, 32'd3, e);
      wr(2'd0, 32'h0000_0005, e);
      wait_until(e + 2);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL periodic_pre irq=%b expected 0", irq); end
      wait_until(e + 3);
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL periodic_first irq=%b expected 1", irq); end
      wait_until(e + 4);
      wr(2'd0, 32'h0000_000D, w);
      checks++;
      if (w != e + 5 || irq !== 1'b0) begin
         errors++;
         $display("FAIL periodic_clear edge=%0d irq=%b expected edge=%0d irq=0", w - e, irq, 5);
      end
      wait_until(e + 6);
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL periodic_second irq=%b expected 1", irq); end
      wait_until(e + 8);
      wr(2'd0, 32'h0000_000D, w);
      checks++;
      if (w != e + 9 || irq !== 1'b1) begin
         errors++;
         $display("FAIL periodic_clear_vs_expiry edge=%0d irq=%b expected edge=9 irq=1", w - e, irq);
      end
      for (int k = 0; k < 3; k++) begin
         wait_until(cyc_cnt + $urandom_range(1, 5));
         rd(2'd2, d, r);
         checks++;
         if (d !== 32'(3 - ((r - 1 - e) % 3))) begin
            errors++;
            $display("FAIL periodic_count got=%0d expected=%0d", d, 3 - ((r - 1 - e) % 3));
         end
      end
      wr(2'd0, 32'h0, e);
   endtask

   task automatic test_watchdog();
      logic [31:0] d;
      int e, last, iv, k;
      do_reset();
      wr(2'd1, 32'd50, e);
      wr(2'd3, 32'h0000_5AA5, e);
      wr(2'd0, 32'h0000_0023, e);
      last = e;
      for (int i = 0; i < 4; i++) begin
         iv = $urandom_range(30, 45);
         wait_until(last + iv - 1);
         checks++;
         if (boot_now !== 1'b0) begin errors++; $display("FAIL wdt_kicked boot_now=%b expected 0", boot_now); end
         wr(2'd3, 32'h0000_5AA5, k);
         checks++;
         if (k != last + iv) begin errors++; $display("FAIL wdt_kick_edge got=%0d expected=%0d", k - last, iv); end
         last = k;
      end
      rd(2'd3, d, e);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL kick_read got=%h expected 0", d); end
      wait_until(last + 19);
      wr(2'd3, 32'h0000_1234, e);
      wait_until(last + 49);
      checks++;
      if (boot_now !== 1'b0) begin errors++; $display("FAIL wdt_early boot_now=%b expected 0", boot_now); end
      wait_until(last + 50);
      checks++;
      if (boot_now !== 1'b1 || boot_sel !== 2'd2 || irq !== 1'b1) begin
         errors++;
         $display("FAIL wdt_expire boot_now=%b boot_sel=%0d irq=%b expected 1/2/1", boot_now, boot_sel, irq);
      end
   endtask

   task automatic test_sticky();
      logic [31:0] d;
      int e;
      wr(2'd0, 32'h0000_0010, e);
      rd(2'd0, d, e);
      checks++;
      if (boot_now !== 1'b1 || boot_sel !== 2'd2 || d !== 32'h1A) begin
         errors++;
         $display("FAIL sticky_csr csr=%h boot_now=%b boot_sel=%0d expected 1a/1/2", d, boot_now, boot_sel);
      end
      wr(2'd0, 32'h0000_0018, e);
      rd(2'd0, d, e);
      checks++;
      if (irq !== 1'b0 || d !== 32'h12) begin
         errors++;
         $display("FAIL sticky_w1c csr=%h irq=%b expected 12/0", d, irq);
      end
      wr(2'd2, 32'd2, e);
      wr(2'd0, 32'h0000_0031, e);
      wait_until(e + 3);
      checks++;
      if (irq !== 1'b1 || boot_now !== 1'b1 || boot_sel !== 2'd2) begin
         errors++;
         $display("FAIL sticky_reexpire irq=%b boot_now=%b boot_sel=%0d expected 1/1/2", irq, boot_now, boot_sel);
      end
   endtask

   task automatic test_bus();
      logic [31:0] d;
      int e;
      do_reset();
      wr(2'd2, 32'd77, e);
      @(posedge clk); #1;
      wb_addr = 2'd2; wb_we = 1'b0; wb_cyc = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         if (i > 1) begin @(posedge clk); #1; end
         checks++;
         if (wb_ack !== ((i % 2) == 0) || wb_rdata !== (((i % 2) == 0) ? 32'd77 : 32'd0)) begin
            errors++;
            $display("FAIL bus_held cycle=%0d ack=%b rdata=%0d expected %0d/%0d", i, wb_ack, wb_rdata, (i % 2) == 0, ((i % 2) == 0) ? 77 : 0);
         end
      end
      @(posedge clk); #1;
      wb_cyc = 1'b0;
      wr(2'd2, 32'hFFFF_FFFF, e);
      rd(2'd2, d, e);
      checks++;
      if (d !== 32'h00FF_FFFF) begin errors++; $display("FAIL count_trunc got=%h expected 00ffffff", d); end
      wr(2'd1, 32'h1234_5678, e);
      rd(2'd1, d, e);
      checks++;
      if (d !== 32'h0034_5678) begin errors++; $display("FAIL reload_trunc got=%h expected 00345678", d); end
      wr(2'd0, 32'hFFFF_FFF6, e);
      rd(2'd0, d, e);
      checks++;
      if (d !== 32'h0000_FF36) begin errors++; $display("FAIL csr_fields got=%h expected 0000ff36", d); end
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_periodic();
      test_watchdog();
      test_sticky();
      test_bus();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
